// File: rtl/edge_cnt_pkg.sv
// rtl/edge_cnt_pkg.sv - shared defaults and wrap/saturate increment helper for edge_event_counter
package edge_cnt_pkg;

   localparam int DEF_WIDTH       = 16;
   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_SATURATE    = 0;

   // Widest counter the helper can serve; callers zero-extend into it.
   localparam int MAX_WIDTH = 64;

   typedef struct packed {
      logic                 ovf;
      logic [MAX_WIDTH-1:0] cnt;
   } inc_result_t;

   // Increment a width-bit count; at all-ones either wrap to 0 or hold, and flag overflow.
   function automatic inc_result_t cnt_inc(input logic [MAX_WIDTH-1:0] cnt,
                                           input int unsigned          width,
                                           input logic                 sat);
      logic [MAX_WIDTH-1:0] all_ones;
      inc_result_t          r;
      if (width >= MAX_WIDTH)
         all_ones = '1;
      else
         all_ones = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
      if (cnt == all_ones) begin
         r.ovf = 1'b1;
         r.cnt = sat ? all_ones : '0;
      end else begin
         r.ovf = 1'b0;
         r.cnt = cnt + MAX_WIDTH'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// rtl/edge_sync_detect.sv - per-channel synchroniser chain with rise/fall edge detection
module edge_sync_detect
   import edge_cnt_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Shift the async input through the synchroniser, then keep one cycle of history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Rise and fall are mutually exclusive: they compare the same two flops.
   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/edge_event_counter.sv
// rtl/edge_event_counter.sv - multi-channel rise/fall event counter with overflow flags and snapshot
module edge_event_counter
   import edge_cnt_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int SATURATE    = DEF_SATURATE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      clr,
   input  logic [CHANNELS-1:0]       sig_in,
   input  logic                      snap,
   output logic [CHANNELS*WIDTH-1:0] rise_cnt,
   output logic [CHANNELS*WIDTH-1:0] fall_cnt,
   output logic [CHANNELS-1:0]       ovf,
   output logic [CHANNELS*WIDTH-1:0] snap_rise,
   output logic [CHANNELS*WIDTH-1:0] snap_fall,
   output logic                      snap_valid
);

   localparam logic SAT_MODE = (SATURATE != 0);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic             rise;
      logic             fall;
      logic [WIDTH-1:0] rise_q;
      logic [WIDTH-1:0] fall_q;
      logic             ovf_q;
      inc_result_t      rise_inc;
      inc_result_t      fall_inc;
      logic             unused_inc_hi;

      edge_sync_detect #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk  (clk),
         .rst  (rst),
         .d    (sig_in[i]),
         .rise (rise),
         .fall (fall)
      );

      // Precompute the next value of each counter under the wrap/saturate rule.
      always_comb begin
         rise_inc = cnt_inc(MAX_WIDTH'(rise_q), WIDTH, SAT_MODE);
         fall_inc = cnt_inc(MAX_WIDTH'(fall_q), WIDTH, SAT_MODE);
      end

      // Helper bits above WIDTH are always zero and carry no information.
      assign unused_inc_hi = |{rise_inc.cnt, fall_inc.cnt};

      // Count edges when enabled; clear beats increment, and ovf is sticky until clear.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
            ovf_q  <= 1'b0;
         end else if (clr) begin
            rise_q <= '0;
            fall_q <= '0;
            ovf_q  <= 1'b0;
         end else if (en) begin
            if (rise) begin
               rise_q <= rise_inc.cnt[WIDTH-1:0];
               if (rise_inc.ovf)
                  ovf_q <= 1'b1;
            end
            if (fall) begin
               fall_q <= fall_inc.cnt[WIDTH-1:0];
               if (fall_inc.ovf)
                  ovf_q <= 1'b1;
            end
         end
      end

      assign rise_cnt[i*WIDTH +: WIDTH] = rise_q;
      assign fall_cnt[i*WIDTH +: WIDTH] = fall_q;
      assign ovf[i]                     = ovf_q;
   end

   // Capture the pre-update live counts on request; clr leaves the snapshot untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_rise  <= '0;
         snap_fall  <= '0;
         snap_valid <= 1'b0;
      end else begin
         snap_valid <= snap;
         if (snap) begin
            snap_rise <= rise_cnt;
            snap_fall <= fall_cnt;
         end
      end
   end

endmodule

// File: tb/tb_edge_event_counter.sv
// tb/tb_edge_event_counter.sv - self-checking bench for edge_event_counter
module tb_edge_event_counter;

   localparam int W  = 4;
   localparam int CH = 4;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic          clr = 1'b0;
   logic          snap = 1'b0;
   logic [CH-1:0] sig_in = '0;

   logic [CH*W-1:0] rise_w, fall_w, srise_w, sfall_w;
   logic [CH*W-1:0] rise_s, fall_s, srise_s, sfall_s;
   logic [CH-1:0]   ovf_w, ovf_s;
   logic            sv_w, sv_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   edge_event_counter #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(S), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_in(sig_in), .snap(snap),
      .rise_cnt(rise_w), .fall_cnt(fall_w), .ovf(ovf_w),
      .snap_rise(srise_w), .snap_fall(sfall_w), .snap_valid(sv_w));

   edge_event_counter #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(S), .SATURATE(1)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_in(sig_in), .snap(snap),
      .rise_cnt(rise_s), .fall_cnt(fall_s), .ovf(ovf_s),
      .snap_rise(srise_s), .snap_fall(sfall_s), .snap_valid(sv_s));

   // Reference model: counts derived from the history of sampled input levels.
   int            m_r  [2][CH];
   int            m_f  [2][CH];
   bit            m_ov [2][CH];
   int            m_sr [2][CH];
   int            m_sf [2][CH];
   bit            m_sv;
   logic [CH-1:0] samp_q[$];

   function automatic void bump(inout int cnt, inout bit ov, input bit sat);
      if (cnt == (1 << W) - 1) begin
         cnt = sat ? cnt : 0;
         ov  = 1'b1;
      end else begin
         cnt = cnt + 1;
      end
   endfunction

   always @(posedge clk or posedge rst) begin : model
      logic [CH-1:0] nw, od;
      if (rst) begin
         samp_q.delete();
         for (int k = 0; k <= S; k++) samp_q.push_back('0);
         for (int m = 0; m < 2; m++)
            for (int c = 0; c < CH; c++) begin
               m_r[m][c] = 0; m_f[m][c] = 0; m_ov[m][c] = 0;
               m_sr[m][c] = 0; m_sf[m][c] = 0;
            end
         m_sv = 1'b0;
      end else begin
         samp_q.push_back(sig_in);
         if (samp_q.size() > S + 2) void'(samp_q.pop_front());
         nw = samp_q[samp_q.size() - 1 - S];
         od = samp_q[samp_q.size() - 2 - S];
         m_sv = snap;
         for (int m = 0; m < 2; m++)
            for (int c = 0; c < CH; c++) begin
               if (snap) begin
                  m_sr[m][c] = m_r[m][c];
                  m_sf[m][c] = m_f[m][c];
               end
               if (clr) begin
                  m_r[m][c] = 0; m_f[m][c] = 0; m_ov[m][c] = 0;
               end else if (en) begin
                  if (nw[c] && !od[c]) bump(m_r[m][c], m_ov[m][c], m == 1);
                  if (!nw[c] && od[c]) bump(m_f[m][c], m_ov[m][c], m == 1);
               end
            end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int sl(input logic [CH*W-1:0] bus, input int c);
      return int'(bus[c*W +: W]);
   endfunction

   task automatic pulse(input int ch, input int hi, input int lo);
      sig_in[ch] = 1'b1;
      repeat (hi) tick();
      sig_in[ch] = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic cmp_model(input int m, input string tag);
      logic [CH*W-1:0] er, ef, esr, esf;
      logic [CH-1:0]   eo;
      for (int c = 0; c < CH; c++) begin
         er[c*W +: W]  = W'(m_r[m][c]);
         ef[c*W +: W]  = W'(m_f[m][c]);
         esr[c*W +: W] = W'(m_sr[m][c]);
         esf[c*W +: W] = W'(m_sf[m][c]);
         eo[c]         = m_ov[m][c];
      end
      chk({tag, " rise_cnt"},   64'(m == 0 ? rise_w  : rise_s),  64'(er));
      chk({tag, " fall_cnt"},   64'(m == 0 ? fall_w  : fall_s),  64'(ef));
      chk({tag, " ovf"},        64'(m == 0 ? ovf_w   : ovf_s),   64'(eo));
      chk({tag, " snap_rise"},  64'(m == 0 ? srise_w : srise_s), 64'(esr));
      chk({tag, " snap_fall"},  64'(m == 0 ? sfall_w : sfall_s), 64'(esf));
      chk({tag, " snap_valid"}, 64'(m == 0 ? sv_w    : sv_s),    64'(m_sv));
   endtask

   typedef struct {
      int sig; int en; int clr; int snap;
      int r; int f; int sv; int sr; int sf;
   } vec_t;

   vec_t tbl[14];

   initial begin
      // Channel 0 cycle table: inputs applied for one edge, expected state after that edge.
      tbl[0]  = '{1, 1, 0, 0,  0, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 0, 0,  0, 0, 0, 0, 0};
      tbl[2]  = '{1, 1, 0, 0,  1, 0, 0, 0, 0};
      tbl[3]  = '{0, 1, 0, 0,  1, 0, 0, 0, 0};
      tbl[4]  = '{0, 1, 0, 0,  1, 0, 0, 0, 0};
      tbl[5]  = '{0, 1, 0, 1,  1, 1, 1, 1, 0};
      tbl[6]  = '{0, 1, 0, 1,  1, 1, 1, 1, 1};
      tbl[7]  = '{1, 0, 0, 0,  1, 1, 0, 1, 1};
      tbl[8]  = '{1, 0, 0, 0,  1, 1, 0, 1, 1};
      tbl[9]  = '{1, 0, 0, 0,  1, 1, 0, 1, 1};
      tbl[10] = '{1, 1, 0, 0,  1, 1, 0, 1, 1};
      tbl[11] = '{0, 1, 1, 0,  0, 0, 0, 1, 1};
      tbl[12] = '{0, 1, 0, 0,  0, 0, 0, 1, 1};
      tbl[13] = '{0, 1, 0, 0,  0, 1, 0, 1, 1};

      // Reset with toggling inputs: every output stays zero.
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         sig_in = ~sig_in;
         tick();
         chk("reset outputs", 64'(|{rise_w, fall_w, ovf_w, srise_w, sfall_w, sv_w,
                                    rise_s, fall_s, ovf_s, srise_s, sfall_s, sv_s}), 64'd0);
      end
      sig_in = '0;
      rst    = 1'b0;
      en     = 1'b1;
      repeat (10) tick();
      chk("idle rise_cnt", 64'(rise_w), 64'd0);
      chk("idle fall_cnt", 64'(fall_w), 64'd0);

      // Cycle-accurate table for latency, snapshot, enable gating and clear.
      for (int i = 0; i < 14; i++) begin
         sig_in = CH'(tbl[i].sig);
         en     = 1'(tbl[i].en);
         clr    = 1'(tbl[i].clr);
         snap   = 1'(tbl[i].snap);
         tick();
         chk($sformatf("vec%0d rise_cnt", i),   64'(rise_w),  64'(tbl[i].r));
         chk($sformatf("vec%0d fall_cnt", i),   64'(fall_w),  64'(tbl[i].f));
         chk($sformatf("vec%0d ovf", i),        64'(ovf_w),   64'd0);
         chk($sformatf("vec%0d snap_valid", i), 64'(sv_w),    64'(tbl[i].sv));
         chk($sformatf("vec%0d snap_rise", i),  64'(srise_w), 64'(tbl[i].sr));
         chk($sformatf("vec%0d snap_fall", i),  64'(sfall_w), 64'(tbl[i].sf));
      end
      en = 1'b1; clr = 1'b0; snap = 1'b0; sig_in = '0;

      // Basic count: five full pulses on channel 0.
      clr = 1'b1; tick(); clr = 1'b0;
      for (int p = 0; p < 5; p++) pulse(0, 4, 4);
      chk("basic rise ch0", 64'(sl(rise_w, 0)), 64'd5);
      chk("basic fall ch0", 64'(sl(fall_w, 0)), 64'd5);
      chk("basic other ch", 64'(rise_w[CH*W-1:W] | fall_w[CH*W-1:W]), 64'd0);

      // Overflow: 17 edges on channel 2, wrap versus saturate, then clear.
      clr = 1'b1; tick(); clr = 1'b0;
      for (int p = 0; p < 17; p++) pulse(2, 4, 4);
      chk("wrap rise ch2", 64'(sl(rise_w, 2)), 64'd1);
      chk("wrap fall ch2", 64'(sl(fall_w, 2)), 64'd1);
      chk("wrap ovf",      64'(ovf_w),         64'b0100);
      chk("sat rise ch2",  64'(sl(rise_s, 2)), 64'd15);
      chk("sat fall ch2",  64'(sl(fall_s, 2)), 64'd15);
      chk("sat ovf",       64'(ovf_s),         64'b0100);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr rise",      64'(rise_w | rise_s), 64'd0);
      chk("clr wrap ovf",  64'(ovf_w),           64'd0);
      chk("clr sat ovf",   64'(ovf_s),           64'd0);

      // Snapshot with clear while an edge is pending on channel 1.
      for (int p = 0; p < 7; p++) pulse(1, 4, 4);
      chk("pre-snap rise ch1", 64'(sl(rise_w, 1)), 64'd7);
      sig_in[1] = 1'b1;
      tick();
      tick();
      snap = 1'b1; clr = 1'b1;
      tick();
      snap = 1'b0; clr = 1'b0;
      chk("atomic snap_rise ch1", 64'(sl(srise_w, 1)), 64'd7);
      chk("atomic snap_valid",    64'(sv_w),           64'd1);
      chk("atomic live ch1",      64'(sl(rise_w, 1)),  64'd0);
      tick();
      chk("atomic snap_valid drop", 64'(sv_w),           64'd0);
      chk("atomic snap hold",       64'(sl(srise_w, 1)), 64'd7);
      chk("atomic no recount",      64'(sl(rise_w, 1)),  64'd0);
      sig_in[1] = 1'b0;
      repeat (4) tick();

      // Randomized run against the reference model.
      for (int n = 0; n < 600; n++) begin
         sig_in = sig_in ^ (CH'($urandom) & CH'($urandom));
         en     = ($urandom_range(0, 9) != 0);
         clr    = ($urandom_range(0, 49) == 0);
         snap   = ($urandom_range(0, 7) == 0);
         tick();
         cmp_model(0, "rand wrap");
         cmp_model(1, "rand sat");
      end
      en = 1'b1; clr = 1'b0; snap = 1'b0; sig_in = '0;
      repeat (4) tick();

      // Asynchronous reset between clock edges.
      clr = 1'b1; tick(); clr = 1'b0;
      for (int p = 0; p < 3; p++) pulse(3, 3, 3);
      chk("pre-rst rise ch3", 64'(sl(rise_w, 3)), 64'd3);
      snap = 1'b1; tick(); snap = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst outputs", 64'(|{rise_w, fall_w, ovf_w, srise_w, sfall_w, sv_w,
                                     rise_s, fall_s, ovf_s, srise_s, sfall_s, sv_s}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
